// File: rtl/rv_mem_pkg.sv
// Shared types and helpers for the data-memory stall controller.
// Access sizes, controller states and the alignment check used on every load/store.
package rv_mem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} stall_state_e;

  // Size 3 is not a legal RV32 width; it is checked as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    if (size == SZ_B) return 1'b0;
    if (size == SZ_H) return addr_lo[0];
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_stall_ctrl_if.sv
// Core/cache/status bundle for the stall controller; master is the controller, slave the environment.
// Core and cache inputs plus status outputs; the cache handshake is req/ready with single-cycle ready pulses.
interface dmem_stall_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_ready;
  logic [DATA_W-1:0] c_rdata;
  logic              stall;
  logic [DATA_W-1:0] rdata;
  logic              wb_kill;
  logic              misalign;
  logic              timeout_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  modport master (
    input  mem_read, mem_write, size, addr, wdata, c_ready, c_rdata,
    output c_req, c_we, c_addr, c_wdata, stall, rdata, wb_kill, misalign,
           timeout_err, stall_cnt, miss_cnt
  );

  modport slave (
    output mem_read, mem_write, size, addr, wdata, c_ready, c_rdata,
    input  c_req, c_we, c_addr, c_wdata, stall, rdata, wb_kill, misalign,
           timeout_err, stall_cnt, miss_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: increments by one per cycle with inc high, holds at all-ones.
// One-cycle update latency; no backpressure.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_stall_ctrl.sv
// Sequences core loads/stores into a variable-latency data cache, stalling the core on a miss.
// Hits complete combinationally in the issue cycle; misses stall through WAIT and retire in a one-cycle DONE.
module dmem_stall_ctrl
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input logic                clk,
  input logic                rst,
  dmem_stall_ctrl_if.master  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  stall_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;
  logic              kill_q;
  logic              timeout_q;
  logic [TW-1:0]     tcnt;

  logic              op, mis;
  logic              go_wait, t_expire;
  logic              c_req, c_we, stall, wb_kill, misalign;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, rdata;
  logic [CNT_W-1:0]  stall_cnt, miss_cnt;

  assign op  = bus.mem_read | bus.mem_write;
  assign mis = is_misaligned(bus.size, bus.addr[1:0]);

  always_comb begin
    state_d  = state_q;
    c_req    = 1'b0;
    c_we     = 1'b0;
    c_addr   = addr_q;
    c_wdata  = wdata_q;
    stall    = 1'b0;
    wb_kill  = 1'b0;
    misalign = 1'b0;
    rdata    = rdata_q;
    go_wait  = 1'b0;
    t_expire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op) begin
          if (mis) begin
            misalign = 1'b1;
            wb_kill  = 1'b1;
          end else begin
            c_req   = 1'b1;
            c_we    = bus.mem_write;
            c_addr  = bus.addr;
            c_wdata = bus.wdata;
            if (bus.c_ready) begin
              rdata = bus.c_rdata;
            end else begin
              stall   = 1'b1;
              go_wait = 1'b1;
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        c_req    = 1'b1;
        c_we     = we_q;
        stall    = 1'b1;
        // A response arriving on the last allowed cycle still wins over the timeout.
        t_expire = !bus.c_ready && (tcnt == T_LAST);
        if (bus.c_ready || t_expire) state_d = S_DONE;
      end
      S_DONE: begin
        wb_kill = kill_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      we_q      <= 1'b0;
      kill_q    <= 1'b0;
      timeout_q <= 1'b0;
      tcnt      <= '0;
    end else begin
      state_q <= state_d;
      if (go_wait) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        we_q    <= bus.mem_write;
        kill_q  <= 1'b0;
        tcnt    <= '0;
      end
      if (state_q == S_WAIT) begin
        tcnt <= tcnt + 1'b1;
        if (bus.c_ready) begin
          rdata_q <= bus.c_rdata;
        end else if (t_expire) begin
          rdata_q   <= '0;
          kill_q    <= 1'b1;
          timeout_q <= 1'b1;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk (clk),
    .rst (rst),
    .inc (go_wait),
    .cnt (miss_cnt)
  );

  assign bus.c_req       = c_req;
  assign bus.c_we        = c_we;
  assign bus.c_addr      = c_addr;
  assign bus.c_wdata     = c_wdata;
  assign bus.stall       = stall;
  assign bus.rdata       = rdata;
  assign bus.wb_kill     = wb_kill;
  assign bus.misalign    = misalign;
  assign bus.timeout_err = timeout_q;
  assign bus.stall_cnt   = stall_cnt;
  assign bus.miss_cnt    = miss_cnt;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Directed bench for dmem_stall_ctrl: a per-cycle vector table plus timeout, reset and saturation sequences.
module tb_dmem_stall_ctrl;
  import rv_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_stall_ctrl_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(2)) bus ();

  dmem_stall_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic        r, rd, wr;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    logic        rdy;
    logic [31:0] crd;
    logic        e_req, e_we;
    logic [31:0] e_caddr, e_wd;
    logic        e_stall, e_kill, e_mis;
    logic [31:0] e_rdata;
    logic [1:0]  e_scnt, e_mcnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string n, input logic r, rd, wr, input logic [1:0] sz,
                              input logic [31:0] a, wd, input logic rdy, input logic [31:0] crd,
                              input logic e_req, e_we, input logic [31:0] e_caddr, e_wd,
                              input logic e_stall, e_kill, e_mis, input logic [31:0] e_rdata,
                              input logic [1:0] e_scnt, e_mcnt);
    vec_t v;
    v.name = n; v.r = r; v.rd = rd; v.wr = wr; v.sz = sz; v.a = a; v.wd = wd;
    v.rdy = rdy; v.crd = crd; v.e_req = e_req; v.e_we = e_we; v.e_caddr = e_caddr;
    v.e_wd = e_wd; v.e_stall = e_stall; v.e_kill = e_kill; v.e_mis = e_mis;
    v.e_rdata = e_rdata; v.e_scnt = e_scnt; v.e_mcnt = e_mcnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 2 time units later, well before the rising edge.
  task automatic drive(input logic r, rd, wr, input logic [1:0] sz, input logic [31:0] a, wd,
                       input logic rdy, input logic [31:0] crd);
    @(negedge clk);
    rst = r; bus.mem_read = rd; bus.mem_write = wr; bus.size = sz; bus.addr = a;
    bus.wdata = wd; bus.c_ready = rdy; bus.c_rdata = crd;
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_read = 0; bus.mem_write = 0; bus.size = 0; bus.addr = 0;
    bus.wdata = 0; bus.c_ready = 0; bus.c_rdata = 0;

    //      name        r rd wr sz addr      wdata         rdy crdata        req we caddr     cwdata        st kl ms rdata         sc mc
    vq.push_back(mk("rst_state", 0,0,0,0, 32'h0,   32'h0,        0, 32'h0,        0,0, 32'h0,   32'h0,        0,0,0, 32'h0,        0,0));
    vq.push_back(mk("hit_ld",    0,1,0,2, 32'h100, 32'h0,        1, 32'hDEADBEEF, 1,0, 32'h100, 32'h0,        0,0,0, 32'hDEADBEEF, 0,0));
    vq.push_back(mk("post_hit",  0,0,0,0, 32'h0,   32'h0,        0, 32'h0,        0,0, 32'h0,   32'h0,        0,0,0, 32'h0,        0,0));
    vq.push_back(mk("st_miss",   0,0,1,2, 32'h204, 32'h12345678, 0, 32'h0,        1,1, 32'h204, 32'h12345678, 1,0,0, 32'h0,        0,0));
    vq.push_back(mk("st_wait1",  0,0,1,2, 32'h204, 32'h12345678, 0, 32'h0,        1,1, 32'h204, 32'h12345678, 1,0,0, 32'h0,        1,1));
    vq.push_back(mk("st_wait2",  0,1,0,0, 32'h888, 32'h0,        1, 32'h0,        1,1, 32'h204, 32'h12345678, 1,0,0, 32'h0,        2,1));
    vq.push_back(mk("st_done",   0,0,1,2, 32'h204, 32'h12345678, 1, 32'h55,       0,0, 32'h0,   32'h0,        0,0,0, 32'h0,        3,1));
    vq.push_back(mk("st_idle",   0,0,0,0, 32'h0,   32'h0,        0, 32'h0,        0,0, 32'h0,   32'h0,        0,0,0, 32'h0,        3,1));
    vq.push_back(mk("rst_cyc",   1,0,0,0, 32'h0,   32'h0,        0, 32'h0,        0,0, 32'h0,   32'h0,        0,0,0, 32'h0,        3,1));
    vq.push_back(mk("post_rst",  0,0,0,0, 32'h0,   32'h0,        0, 32'h0,        0,0, 32'h0,   32'h0,        0,0,0, 32'h0,        0,0));
    vq.push_back(mk("ld_miss",   0,1,0,1, 32'h302, 32'h0,        0, 32'h0,        1,0, 32'h302, 32'h0,        1,0,0, 32'h0,        0,0));
    vq.push_back(mk("ld_wait",   0,1,0,1, 32'h302, 32'h0,        1, 32'hCAFEF00D, 1,0, 32'h302, 32'h0,        1,0,0, 32'h0,        1,1));
    vq.push_back(mk("ld_done",   0,1,0,1, 32'h302, 32'h0,        0, 32'h0,        0,0, 32'h0,   32'h0,        0,0,0, 32'hCAFEF00D, 2,1));
    vq.push_back(mk("ld_idle",   0,0,0,0, 32'h0,   32'h0,        0, 32'h0,        0,0, 32'h0,   32'h0,        0,0,0, 32'hCAFEF00D, 2,1));
    vq.push_back(mk("rdwr_hit",  0,1,1,0, 32'h401, 32'h77,       1, 32'h11,       1,1, 32'h401, 32'h77,       0,0,0, 32'h11,       2,1));
    vq.push_back(mk("mis_w",     0,1,0,2, 32'h102, 32'h0,        0, 32'h0,        0,0, 32'h0,   32'h0,        0,1,1, 32'hCAFEF00D, 2,1));
    vq.push_back(mk("mis_h",     0,0,1,1, 32'h103, 32'h0,        0, 32'h0,        0,0, 32'h0,   32'h0,        0,1,1, 32'hCAFEF00D, 2,1));
    vq.push_back(mk("mis_sz3",   0,1,0,3, 32'h106, 32'h0,        1, 32'h44,       0,0, 32'h0,   32'h0,        0,1,1, 32'hCAFEF00D, 2,1));
    vq.push_back(mk("ok_byte",   0,1,0,0, 32'h103, 32'h0,        1, 32'h22,       1,0, 32'h103, 32'h0,        0,0,0, 32'h22,       2,1));
    vq.push_back(mk("ok_half",   0,1,0,1, 32'h102, 32'h0,        1, 32'h33,       1,0, 32'h102, 32'h0,        0,0,0, 32'h33,       2,1));
    vq.push_back(mk("idle_rdy",  0,0,0,0, 32'h0,   32'h0,        1, 32'h99,       0,0, 32'h0,   32'h0,        0,0,0, 32'hCAFEF00D, 2,1));

    do_reset();
    do_reset();
    idle();
    chk("rst_c_addr", bus.c_addr, 32'h0);
    chk("rst_c_wdata", bus.c_wdata, 32'h0);
    chk("rst_state_q", 32'(dut.state_q), 32'(S_IDLE));

    foreach (vq[i]) begin
      drive(vq[i].r, vq[i].rd, vq[i].wr, vq[i].sz, vq[i].a, vq[i].wd, vq[i].rdy, vq[i].crd);
      chk({vq[i].name, ".c_req"}, 32'(bus.c_req), 32'(vq[i].e_req));
      if (vq[i].e_req) begin
        chk({vq[i].name, ".c_we"}, 32'(bus.c_we), 32'(vq[i].e_we));
        chk({vq[i].name, ".c_addr"}, bus.c_addr, vq[i].e_caddr);
        if (vq[i].e_we) chk({vq[i].name, ".c_wdata"}, bus.c_wdata, vq[i].e_wd);
      end
      chk({vq[i].name, ".stall"}, 32'(bus.stall), 32'(vq[i].e_stall));
      chk({vq[i].name, ".wb_kill"}, 32'(bus.wb_kill), 32'(vq[i].e_kill));
      chk({vq[i].name, ".misalign"}, 32'(bus.misalign), 32'(vq[i].e_mis));
      chk({vq[i].name, ".rdata"}, bus.rdata, vq[i].e_rdata);
      chk({vq[i].name, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(vq[i].e_scnt));
      chk({vq[i].name, ".miss_cnt"}, 32'(bus.miss_cnt), 32'(vq[i].e_mcnt));
      chk({vq[i].name, ".timeout_err"}, 32'(bus.timeout_err), 32'h0);
    end

    // Timeout: a good load first so the abandoned one must visibly clear rdata.
    do_reset();
    drive(0, 1, 0, 2, 32'h600, 0, 0, 0);
    drive(0, 1, 0, 2, 32'h600, 0, 1, 32'h13572468);
    drive(0, 1, 0, 2, 32'h600, 0, 0, 0);
    chk("pre_to_rdata", bus.rdata, 32'h13572468);
    idle();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 2, 32'h500, 0, 0, 0);
      chk($sformatf("to_stall%0d", i), 32'(bus.stall), 32'h1);
      chk($sformatf("to_req%0d", i), 32'(bus.c_req), 32'h1);
      chk($sformatf("to_err_early%0d", i), 32'(bus.timeout_err), 32'h0);
    end
    drive(0, 1, 0, 2, 32'h500, 0, 0, 0);
    chk("to_done_stall", 32'(bus.stall), 32'h0);
    chk("to_done_req", 32'(bus.c_req), 32'h0);
    chk("to_done_rdata", bus.rdata, 32'h0);
    chk("to_done_kill", 32'(bus.wb_kill), 32'h1);
    chk("to_done_err", 32'(bus.timeout_err), 32'h1);
    idle();
    chk("to_idle_err", 32'(bus.timeout_err), 32'h1);
    chk("to_idle_kill", 32'(bus.wb_kill), 32'h0);
    chk("to_stall_sat", 32'(bus.stall_cnt), 32'h3);
    drive(0, 1, 0, 2, 32'h700, 0, 1, 32'h42);
    chk("to_hit_rdata", bus.rdata, 32'h42);
    chk("to_hit_stall", 32'(bus.stall), 32'h0);
    chk("to_sticky", 32'(bus.timeout_err), 32'h1);

    // Reset on the second WAIT cycle, then a late response.
    do_reset();
    drive(0, 1, 0, 2, 32'h800, 0, 0, 0);
    chk("rw_err_clr", 32'(bus.timeout_err), 32'h0);
    chk("rw_issue_stall", 32'(bus.stall), 32'h1);
    drive(0, 1, 0, 2, 32'h800, 0, 0, 0);
    chk("rw_state_wait", 32'(dut.state_q), 32'(S_WAIT));
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 32'hBAD);
    chk("rw_req", 32'(bus.c_req), 32'h0);
    chk("rw_stall", 32'(bus.stall), 32'h0);
    chk("rw_scnt", 32'(bus.stall_cnt), 32'h0);
    chk("rw_mcnt", 32'(bus.miss_cnt), 32'h0);
    chk("rw_state", 32'(dut.state_q), 32'(S_IDLE));
    chk("rw_rdata", bus.rdata, 32'h0);
    idle();
    chk("rw_rdata_after", bus.rdata, 32'h0);
    chk("rw_state_after", 32'(dut.state_q), 32'(S_IDLE));

    // Saturation of the 2-bit miss counter.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      drive(0, 1, 0, 2, 32'h900, 0, 0, 0);
      drive(0, 1, 0, 2, 32'h900, 0, 1, 32'(k));
      drive(0, 1, 0, 2, 32'h900, 0, 0, 0);
      chk($sformatf("sat_rdata%0d", k), bus.rdata, 32'(k));
      idle();
      chk($sformatf("sat_miss%0d", k), 32'(bus.miss_cnt), (k > 3) ? 32'h3 : 32'(k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
